// File: rtl/alu_pkg.sv
// Shared ALU definitions: FunSel codes, flag bit positions and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] FS_A    = 4'h0;
  localparam logic [3:0] FS_B    = 4'h1;
  localparam logic [3:0] FS_NOTA = 4'h2;
  localparam logic [3:0] FS_NOTB = 4'h3;
  localparam logic [3:0] FS_ADD  = 4'h4;
  localparam logic [3:0] FS_SUB  = 4'h5;
  localparam logic [3:0] FS_CMP  = 4'h6;
  localparam logic [3:0] FS_AND  = 4'h7;
  localparam logic [3:0] FS_OR   = 4'h8;
  localparam logic [3:0] FS_NAND = 4'h9;
  localparam logic [3:0] FS_XOR  = 4'hA;
  localparam logic [3:0] FS_LSL  = 4'hB;
  localparam logic [3:0] FS_LSR  = 4'hC;
  localparam logic [3:0] FS_ASR  = 4'hD;
  localparam logic [3:0] FS_CSR  = 4'hE;
  localparam logic [3:0] FS_CSL  = 4'hF;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// Two-input one-hot grant. Round-robin on ties by default; ALU_ARB_FIXED_PRIO_EN selects fixed req0 priority.
module alu_rr_grant (
  input  logic [1:0] valid_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       last_i,
`endif
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_o = 2'b01;
`else
      // last_i is the ID served most recently; the other one wins the tie
      grant_o = last_i ? 2'b01 : 2'b10;
`endif
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU. Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       Clock,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_funsel,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_funsel,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [3:0] alu_funsel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic [3:0] rsp_flag
);

  arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] funsel_q, funsel_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       id_q, id_d;
  logic [7:0] data_q, data_d;
  logic [3:0] flag_q, flag_d;
  logic [1:0] gnt;
  logic       idle;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif

  alu_rr_grant u_grant (
    .valid_i ({req1_valid, req0_valid}),
    .grant_o (gnt)
`ifndef ALU_ARB_FIXED_PRIO_EN
    , .last_i(last_q)
`endif
  );

  assign idle       = (state_q == ST_IDLE);
  // readies are gated by RESET so they read 0 while reset is held
  assign req0_ready = idle & gnt[0] & ~RESET;
  assign req1_ready = idle & gnt[1] & ~RESET;
  assign rsp_valid  = (state_q == ST_RESP);
  assign alu_funsel = funsel_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_id     = id_q;
  assign rsp_data   = data_q;
  assign rsp_flag   = flag_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funsel_d = funsel_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    data_d   = data_q;
    flag_d   = flag_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          funsel_d = gnt[1] ? req1_funsel : req0_funsel;
          a_d      = gnt[1] ? req1_a      : req0_a;
          b_d      = gnt[1] ? req1_b      : req0_b;
          id_d     = gnt[1];
          cnt_d    = 4'(SETTLE_CYCLES);
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d   = gnt[1];
`endif
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q <= 4'd1) begin
          data_d  = alu_out;
          flag_d  = alu_flag;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      funsel_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      flag_q   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funsel_q <= funsel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      data_q   <= data_d;
      flag_q   <= flag_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: SETTLE_CYCLES=1 and =4 instances driving a stand-in ALU model.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic Clock = 1'b0;
  logic RESET;
  int   tests = 0;
  int   fails = 0;

  // SETTLE_CYCLES = 1 instance
  logic       r0v, r1v, r0rdy, r1rdy, rv, rrdy, rid;
  logic [3:0] r0fs, r1fs, afs, aflag, rflag;
  logic [7:0] r0a, r0b, r1a, r1b, aa, ab, aout, rdata;
  // SETTLE_CYCLES = 4 instance
  logic       c0v, c1v, c0rdy, c1rdy, rv4, rrdy4, rid4;
  logic [3:0] c0fs, c1fs, afs4, aflag4, rflag4;
  logic [7:0] c0a, c0b, c1a, c1b, aa4, ab4, aout4, rdata4;

  function automatic logic [11:0] alu_model(logic [3:0] fs, logic [7:0] a, logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; r = a;
    case (fs)
      FS_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      FS_SUB: begin
        r = a - b; c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      FS_AND:  r = a & b;
      FS_OR:   r = a | b;
      FS_XOR:  r = a ^ b;
      default: r = a;
    endcase
    return {(r == 8'h00), c, r[7], v, r};
  endfunction

  assign {aflag, aout}   = alu_model(afs, aa, ab);
  assign {aflag4, aout4} = alu_model(afs4, aa4, ab4);

  alu_arbiter #(.SETTLE_CYCLES(1)) dut (
    .Clock(Clock), .RESET(RESET),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_funsel(r0fs), .req0_a(r0a), .req0_b(r0b),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_funsel(r1fs), .req1_a(r1a), .req1_b(r1b),
    .alu_funsel(afs), .alu_a(aa), .alu_b(ab), .alu_out(aout), .alu_flag(aflag),
    .rsp_valid(rv), .rsp_ready(rrdy), .rsp_id(rid), .rsp_data(rdata), .rsp_flag(rflag)
  );

  alu_arbiter #(.SETTLE_CYCLES(4)) dut4 (
    .Clock(Clock), .RESET(RESET),
    .req0_valid(c0v), .req0_ready(c0rdy), .req0_funsel(c0fs), .req0_a(c0a), .req0_b(c0b),
    .req1_valid(c1v), .req1_ready(c1rdy), .req1_funsel(c1fs), .req1_a(c1a), .req1_b(c1b),
    .alu_funsel(afs4), .alu_a(aa4), .alu_b(ab4), .alu_out(aout4), .alu_flag(aflag4),
    .rsp_valid(rv4), .rsp_ready(rrdy4), .rsp_id(rid4), .rsp_data(rdata4), .rsp_flag(rflag4)
  );

  initial forever #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic [3:0] fs;
    logic [7:0] a, b, data;
    logic [3:0] flag;
  } vec_t;

  task automatic pulse_reset();
    @(negedge Clock);
    RESET = 1'b1;
    @(negedge Clock);
    RESET = 1'b0;
  endtask

  task automatic single(input int i, input vec_t v);
    @(negedge Clock);
    if (v.id) begin r1v = 1'b1; r1fs = v.fs; r1a = v.a; r1b = v.b; end
    else      begin r0v = 1'b1; r0fs = v.fs; r0a = v.a; r0b = v.b; end
    #1;
    check($sformatf("v%0d ready", i), {r1rdy, r0rdy}, v.id ? 2'b10 : 2'b01);
    @(posedge Clock);
    @(negedge Clock);
    check($sformatf("v%0d alu", i), {afs, aa, ab}, {v.fs, v.a, v.b});
    check($sformatf("v%0d issue", i), {rv, r1rdy, r0rdy}, 3'b000);
    r0v = 1'b0; r1v = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    check($sformatf("v%0d rsp", i), {rv, rid, rdata, rflag}, {1'b1, v.id, v.data, v.flag});
    rrdy = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check($sformatf("v%0d done", i), {rv, rrdy}, 2'b01);
    rrdy = 1'b0;
  endtask

  initial begin
    vec_t vecs[7];
    logic exp_g[4];
    logic got_g[4];
    int   g_cyc[4];
    int   ng, nr, cyc, quiet;

    vecs[0] = '{1'b0, FS_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vecs[1] = '{1'b1, FS_SUB, 8'h10, 8'h20, 8'hF0, 4'b0110};
    vecs[2] = '{1'b0, FS_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[3] = '{1'b1, FS_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vecs[4] = '{1'b0, FS_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vecs[5] = '{1'b1, FS_XOR, 8'hAA, 8'hAA, 8'h00, 4'b1000};
    vecs[6] = '{1'b0, FS_SUB, 8'h05, 8'h05, 8'h00, 4'b1000};
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    RESET = 1'b1;
    {r0v, r1v, rrdy, c0v, c1v, rrdy4} = '0;
    {r0fs, r1fs, c0fs, c1fs} = '0;
    {r0a, r0b, r1a, r1b, c0a, c0b, c1a, c1b} = '0;
    #12;
    check("reset outputs", {r0rdy, r1rdy, rv, rid, rdata, rflag, afs, aa, ab}, '0);
    @(negedge Clock);
    RESET = 1'b0;

    // round-robin / fixed-priority tie handling with rsp_ready held high
    @(negedge Clock);
    r0v = 1'b1; r0fs = FS_SUB; r0a = 8'h10; r0b = 8'h20;
    r1v = 1'b1; r1fs = FS_AND; r1a = 8'hF0; r1b = 8'h3C;
    rrdy = 1'b1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 4 && cyc < 60) begin
      #1;
      if (r0rdy && r1rdy) check("both ready", 2'b11, 2'b01);
      if ((r0rdy || r1rdy) && ng < 4) begin
        got_g[ng] = r1rdy; g_cyc[ng] = cyc; ng++;
      end
      if (rv) begin
        check($sformatf("rr rsp%0d id", nr), rid, exp_g[nr]);
        check($sformatf("rr rsp%0d data", nr), {rdata, rflag}, exp_g[nr] ? 12'h300 : 12'hF06);
        nr++;
      end
      @(negedge Clock);
      cyc++;
    end
    check("rr responses", nr, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ng) check($sformatf("rr grant%0d", k), got_g[k], exp_g[k]);
      if (k > 0 && k < ng) check($sformatf("rr spacing%0d", k), g_cyc[k] - g_cyc[k-1], 3);
    end
    r0v = 1'b0; r1v = 1'b0; rrdy = 1'b0;
    pulse_reset();

    for (int i = 0; i < 7; i++) single(i, vecs[i]);

    // backpressure: hold RESP for 5 cycles with req0 pending
    @(negedge Clock);
    r1v = 1'b1; r1fs = FS_AND; r1a = 8'hF0; r1b = 8'h3C;
    @(posedge Clock);
    @(negedge Clock);
    r1v = 1'b0;
    r0v = 1'b1; r0fs = FS_ADD; r0a = 8'h7F; r0b = 8'h01;
    @(posedge Clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      check($sformatf("bp hold%0d rsp", k), {rv, rid, rdata, rflag}, {1'b1, 1'b1, 8'h30, 4'h0});
      check($sformatf("bp hold%0d alu", k), {r0rdy, r1rdy, afs, aa, ab}, {2'b00, FS_AND, 8'hF0, 8'h3C});
      @(posedge Clock);
    end
    @(negedge Clock);
    rrdy = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    rrdy = 1'b0;
    check("bp release", {rv, r0rdy}, 2'b01);
    @(posedge Clock);
    @(negedge Clock);
    r0v = 1'b0;
    check("bp next alu", {afs, aa, ab}, {FS_ADD, 8'h7F, 8'h01});
    @(posedge Clock);
    @(negedge Clock);
    check("bp next rsp", {rv, rid, rdata, rflag}, {1'b1, 1'b0, 8'h80, 4'b0011});
    rrdy = 1'b1;
    @(negedge Clock);
    rrdy = 1'b0;

    // async reset during ISSUE on the settle-4 instance
    @(negedge Clock);
    c0v = 1'b1; c0fs = FS_ADD; c0a = 8'h12; c0b = 8'h34;
    @(posedge Clock);
    @(negedge Clock);
    check("rst pre alu", {afs4, aa4, ab4}, {FS_ADD, 8'h12, 8'h34});
    @(posedge Clock);
    #2;
    RESET = 1'b1;
    #1;
    check("rst async", {c0rdy, c1rdy, rv4, rid4, rdata4, rflag4, afs4, aa4, ab4}, '0);
    @(negedge Clock);
    c0v = 1'b0;
    rrdy4 = 1'b1;
    #2;
    RESET = 1'b0;
    quiet = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      if (rv4) quiet++;
    end
    check("rst no rsp", quiet, 0);
    rrdy4 = 1'b0;

    // settle window of 4 cycles
    c0v = 1'b1; c0fs = FS_SUB; c0a = 8'h55; c0b = 8'h11;
    #1;
    check("s4 ready", {c1rdy, c0rdy}, 2'b01);
    @(posedge Clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      c0v = 1'b0;
      check($sformatf("s4 wait%0d", k), {rv4, aa4, ab4}, {1'b0, 8'h55, 8'h11});
      @(posedge Clock);
    end
    @(negedge Clock);
    check("s4 rsp", {rv4, rid4, rdata4, rflag4}, {1'b1, 1'b0, 8'h44, 4'h0});
    rrdy4 = 1'b1;
    @(negedge Clock);
    check("s4 done", rv4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU: accepts operation requests (FunSel, A, B) from two independent masters, grants one at a time, drives the ALU operand and function inputs, holds them for a settle window, then returns the ALU result and flag nibble with the requester's ID. It sits between the register-file/control masters and the single combinational ALU instance and is the only block allowed to drive the ALU inputs.

## Interface
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before the result is captured; legal range 1–15.
- Clock  in  1  rising-edge system clock
- RESET  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  requester n has an operation pending
- req0_ready / req1_ready  out  1  request n is accepted this cycle
- req0_funsel / req1_funsel  in  4  ALU function code
- req0_a, req0_b / req1_a, req1_b  in  8  operands
- alu_funsel  out  4  to ALU FunSel
- alu_a, alu_b  out  8  to ALU A, B
- alu_out  in  8  ALU OutALU
- alu_flag  in  4  ALU OutFlag {Z, C, N, V}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  8  captured ALU result
- rsp_flag  out  4  captured flags {Z, C, N, V}

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: grant logic is active. If exactly one reqN_valid is high, that reqN_ready is high. If both are high, the round-robin pointer chooses: grant the requester not served last. The ready signals are never both high. Accept = valid && ready. On accept, latch funsel/a/b into alu_* outputs, record the ID, load the settle counter with SETTLE_CYCLES, update the pointer, and go to ISSUE.
- ISSUE: alu_* stay constant. The counter decrements each cycle. When it reaches 1, capture rsp_data = alu_out and rsp_flag = alu_flag, then go to RESP.
- RESP: rsp_valid is high and the response fields are stable. On rsp_valid && rsp_ready, go to IDLE. The readies stay low throughout ISSUE and RESP.
- alu_* hold their last values in IDLE and RESP and change only on accept. This keeps the ALU's input-sensitive flag updates from firing spuriously, and preserves the ALU's sticky carry for CSL chains.
- The arbiter never resets the ALU. Flag history belongs to the ALU.

## Timing
- Accept at edge n: alu_* update at n, capture at n+SETTLE_CYCLES, rsp_valid high from n+SETTLE_CYCLES.
- Minimum spacing between accepts is SETTLE_CYCLES+2 cycles, with rsp_ready held high.
- A request arriving in the same cycle the FSM re-enters IDLE can be accepted on the next edge. No combinational path runs from rsp_ready to reqN_ready.
- A requester that drops valid before ready is simply not granted. No request is lost once accepted.
- Reset values: all ready 0; rsp_valid 0; rsp_id 0; rsp_data 0x00; rsp_flag 0x0; alu_funsel 0x0; alu_a and alu_b 0x00; state IDLE; pointer set so that req0 wins the first tie.
- RESET asserted mid-operation aborts immediately: no response is produced and the in-flight request is dropped. Requesters must re-issue.
- rsp_ready while rsp_valid is low is ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: the tie-break is fixed priority, req0 always wins, and the pointer logic is removed.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit FunSel constants (FS_A … FS_CSL, 0x0–0xF);
  - the flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0);
  - the FSM state typedef.
- One sub-module, alu_rr_grant: a two-input grant function taking valids and pointer and returning one-hot grants. It is compiled as a fixed-priority variant under the macro.

## Test plan
- Single request, SETTLE_CYCLES=1: req0 funsel=0x4, a=0x7F, b=0x01 → req0_ready one cycle; rsp_valid two cycles later with rsp_id=0, rsp_data=0x80, rsp_flag=0b0011 (N, V set).
- Both valid continuously with round-robin: req0 0x5 (0x10,0x20) and req1 0x7 (0xF0,0x3C) → grants alternate 0,1,0,1. Responses carry the matching IDs and data 0xF0, 0x30.
- Same stimulus with ALU_ARB_FIXED_PRIO_EN → req0 is granted every time while it remains valid; req1 is never granted.
- Backpressure: rsp_ready held low 5 cycles → rsp_valid and data stable, readies low, alu_* unchanged; the release frees IDLE one cycle later.
- RESET pulse during ISSUE → every output at its reset value asynchronously, no response appears, and the next request is accepted normally.
- SETTLE_CYCLES=4: accept → rsp_valid exactly 4 cycles later; alu_a and alu_b unchanged across the window.
